// File: rtl/ones_count_accumulator_if.sv
// Handshake bundle for ones_count_accumulator: sample input side, frame-total output side.
// ONES_ACC_PEAK_EN adds the out_peak field.
interface ones_count_accumulator_if #(
    parameter int SUM_W = 5
);
    logic             in_valid;
    logic [1:0]       in_count;
    logic             in_ready;
    logic             out_valid;
    logic [SUM_W-1:0] out_sum;
    logic             out_ready;
    logic             busy;
`ifdef ONES_ACC_PEAK_EN
    logic [1:0]       out_peak;

    modport master (
        output in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_sum, busy, out_peak
    );
    modport slave (
        input  in_valid, in_count, out_ready,
        output in_ready, out_valid, out_sum, busy, out_peak
    );
`else
    modport master (
        output in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );
    modport slave (
        input  in_valid, in_count, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
`endif
endinterface

// File: rtl/ones_count_accumulator.sv
// Sums FRAME_LEN 2-bit ones counts per frame and presents the total over valid/ready.
// ONES_ACC_PEAK_EN: also report the largest count seen in the frame on out_peak.
module ones_count_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ones_count_accumulator_if.slave   io
);
    localparam int IDX_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             xfer;
    logic [SUM_W-1:0] cnt_ext;
    logic [SUM_W-1:0] acc_sum;
    logic [IDX_W-1:0] idx_inc;
    logic             last;

`ifdef ONES_ACC_PEAK_EN
    logic [1:0] pk_q, pk_d;
    logic [1:0] peak_q, peak_d;
    logic [1:0] pk_new;
`endif

    assign accept  = io.in_valid & in_ready_q;
    assign xfer    = out_valid_q & io.out_ready;
    assign cnt_ext = SUM_W'(io.in_count);
    assign acc_sum = acc_q + cnt_ext;
    assign idx_inc = idx_q + IDX_W'(1);
    assign last    = (idx_inc == IDX_W'(FRAME_LEN));

`ifdef ONES_ACC_PEAK_EN
    assign pk_new  = (io.in_count > pk_q) ? io.in_count : pk_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
`ifdef ONES_ACC_PEAK_EN
        pk_d    = pk_q;
        peak_d  = peak_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = cnt_ext;
                    idx_d = IDX_W'(1);
`ifdef ONES_ACC_PEAK_EN
                    pk_d  = io.in_count;
`endif
                    if (FRAME_LEN == 1) begin
                        state_d = DONE;
                        sum_d   = cnt_ext;
`ifdef ONES_ACC_PEAK_EN
                        peak_d  = io.in_count;
`endif
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // Gaps (no accept) simply hold acc/idx.
                if (accept) begin
                    acc_d = acc_sum;
                    idx_d = idx_inc;
`ifdef ONES_ACC_PEAK_EN
                    pk_d  = pk_new;
`endif
                    if (last) begin
                        state_d = DONE;
                        sum_d   = acc_sum;
`ifdef ONES_ACC_PEAK_EN
                        peak_d  = pk_new;
`endif
                    end
                end
            end
            DONE: begin
                if (xfer) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef ONES_ACC_PEAK_EN
                    pk_d    = 2'd0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Handshake outputs are registered from the next state so they line up with it.
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d != DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ONES_ACC_PEAK_EN
            pk_q        <= 2'd0;
            peak_q      <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef ONES_ACC_PEAK_EN
            pk_q        <= pk_d;
            peak_q      <= peak_d;
`endif
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_sum   = sum_q;
    assign io.busy      = busy_q;
`ifdef ONES_ACC_PEAK_EN
    assign io.out_peak  = peak_q;
`endif

endmodule
